// File: rtl/mult_div_unit.sv
// Iterative radix-2 multiply/divide unit with architectural HI/LO registers.
// One shared 64-bit accumulator serves both shift-add multiply and restoring divide.
module mult_div_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] srca,
    input  logic [31:0] srcb,
    input  logic        flush,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t      state, state_nxt;
    logic [5:0]  cnt;
    logic [63:0] acc;
    logic [31:0] opd;
    logic        is_div, neg_q, neg_r, div_zero;

    logic        accept, is_md, sgn, sign_a, sign_b;
    logic [31:0] mag_a, mag_b;
    logic [32:0] add_sum, rem_sh, diff;
    logic [63:0] step, prod;
    logic [31:0] quo, rem, res_hi, res_lo;

    assign accept = (state == IDLE) && start && !flush;
    assign is_md  = ~op[2];
    assign sgn    = ~op[0];
    assign sign_a = sgn & srca[31];
    assign sign_b = sgn & srcb[31];
    assign mag_a  = sign_a ? -srca : srca;
    assign mag_b  = sign_b ? -srcb : srcb;

    // Multiply: acc = {partial product, remaining multiplier bits}.
    // Divide:   acc = {remainder, dividend bits shifting into quotient}.
    assign add_sum = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opd} : 33'd0);
    assign rem_sh  = {acc[63:32], acc[31]};
    assign diff    = rem_sh - {1'b0, opd};
    assign step    = !is_div   ? {add_sum, acc[31:1]} :
                     diff[32]  ? {rem_sh[31:0], acc[30:0], 1'b0} :
                                 {diff[31:0], acc[30:0], 1'b1};

    assign prod   = neg_q ? -acc : acc;
    assign quo    = acc[31:0];
    assign rem    = acc[63:32];
    // Remainder keeps the dividend's sign, which also restores raw srca on divide-by-zero.
    assign res_hi = is_div ? (neg_r ? -rem : rem) : prod[63:32];
    assign res_lo = !is_div  ? prod[31:0] :
                    div_zero ? 32'hFFFF_FFFF :
                    (neg_q ? -quo : quo);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept && is_md) state_nxt = RUN;
            RUN:     if (flush) state_nxt = IDLE;
                     else if (cnt == 6'd31) state_nxt = FIX;
            FIX:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            acc      <= '0;
            opd      <= '0;
            is_div   <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            div_zero <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            busy <= (state_nxt != IDLE);
            case (state)
                IDLE: if (accept) begin
                    if (is_md) begin
                        cnt      <= '0;
                        acc      <= {32'd0, op[1] ? mag_a : mag_b};
                        opd      <= op[1] ? mag_b : mag_a;
                        is_div   <= op[1];
                        neg_q    <= sign_a ^ sign_b;
                        neg_r    <= sign_a & op[1];
                        div_zero <= (srcb == 32'd0);
                    end else if (op == 3'b100) begin
                        hi <= srca;
                    end else if (op == 3'b101) begin
                        lo <= srca;
                    end
                end
                RUN: if (!flush) begin
                    acc <= step;
                    cnt <= cnt + 6'd1;
                end
                FIX: if (!flush) begin
                    hi   <= res_hi;
                    lo   <= res_lo;
                    done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: stimulus pushes expected HI/LO and due cycle,
// a negedge monitor pops and compares on every done pulse.
module tb_mult_div_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    logic [2:0]  op = '0;
    logic [31:0] srca = '0;
    logic [31:0] srcb = '0;
    logic        busy, done;
    logic [31:0] hi, lo;

    mult_div_unit dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .srca(srca), .srcb(srcb),
        .flush(flush), .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          due;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          done_cnt = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Architectural result computed with plain integer arithmetic.
    function automatic logic [63:0] ref_model(input logic [2:0] o, input logic [31:0] a,
                                              input logic [31:0] b);
        longint      sa, sbv;
        logic [63:0] r;
        r = '0;
        case (o)
            3'd0: begin
                sa  = longint'($signed(a));
                sbv = longint'($signed(b));
                r   = 64'(sa * sbv);
            end
            3'd1: r = {32'd0, a} * {32'd0, b};
            3'd2, 3'd3: begin
                if (b == 32'd0)
                    r = {a, 32'hFFFF_FFFF};
                else if (o == 3'd2 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
                    r = {32'h0, 32'h8000_0000};
                else if (o == 3'd2)
                    r = {32'($signed(a) % $signed(b)), 32'($signed(a) / $signed(b))};
                else
                    r = {a % b, a / b};
            end
            default: r = {m_hi, m_lo};
        endcase
        return r;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (!rst && done) begin
            done_cnt++;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_done: got done=1 expected no pending result (cycle %0d)", cyc);
            end else begin
                e = sb.pop_front();
                chk("result_hi", hi, e.hi);
                chk("result_lo", lo, e.lo);
                chk("done_cycle", 32'(cyc), 32'(e.due));
                m_hi = e.hi;
                m_lo = e.lo;
            end
        end
    end

    // Called at a negedge with busy=0; returns at the negedge after the accepting edge.
    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] r;
        start = 1'b1; op = o; srca = a; srcb = b;
        @(negedge clk);
        start = 1'b0;
        if (o < 3'd4) begin
            r = ref_model(o, a, b);
            sb.push_back('{hi: r[63:32], lo: r[31:0], due: cyc + 33});
        end else if (o == 3'd4) begin
            m_hi = a;
            chk("mthi", hi, a);
        end else if (o == 3'd5) begin
            m_lo = a;
            chk("mtlo", lo, a);
        end else begin
            chk("ignored_op_hi", hi, m_hi);
            chk("ignored_op_lo", lo, m_lo);
        end
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got no done expected done within 60 cycles");
        end
    endtask

    initial begin
        int          d0;
        logic [2:0]  o;
        logic [31:0] a, b;

        @(negedge clk);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_hi", hi, 32'd0);
        chk("reset_lo", lo, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Async reset in the middle of a MULTU
        issue(3'd4, 32'hDEAD_BEEF, 32'd0);
        issue(3'd1, 32'h1234_5678, 32'h9ABC_DEF0);
        repeat (10) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_busy", 32'(busy), 32'd0);
        chk("async_rst_done", 32'(done), 32'd0);
        chk("async_rst_hi", hi, 32'd0);
        chk("async_rst_lo", lo, 32'd0);
        sb.delete();
        m_hi = '0;
        m_lo = '0;
        @(negedge clk);
        rst = 1'b0;
        d0 = done_cnt;
        repeat (40) @(negedge clk);
        chk("no_done_after_rst", 32'(done_cnt), 32'(d0));

        issue(3'd0, 32'hFFFF_FFFE, 32'h0000_0003);
        wait_done();
        issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done();

        // Back-to-back: second start lands in the done cycle
        issue(3'd3, 32'd100, 32'd7);
        wait_done();
        issue(3'd2, 32'hFFFF_FFF9, 32'd2);
        chk("b2b_busy", 32'(busy), 32'd1);
        wait_done();

        issue(3'd3, 32'h0000_1234, 32'd0);
        wait_done();
        issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done();
        issue(3'd2, 32'hFFFF_FF00, 32'd0);
        wait_done();

        // Flush at iteration 10
        issue(3'd5, 32'hCAFE_F00D, 32'd0);
        issue(3'd0, 32'd5, 32'd5);
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_busy", 32'(busy), 32'd0);
        void'(sb.pop_back());
        d0 = done_cnt;
        repeat (40) @(negedge clk);
        chk("flush_no_done", 32'(done_cnt), 32'(d0));
        chk("flush_lo", lo, 32'hCAFE_F00D);
        chk("flush_hi", hi, m_hi);

        // Flush in IDLE discards a simultaneous start
        flush = 1'b1; start = 1'b1; op = 3'd4; srca = 32'h5555_AAAA;
        @(negedge clk);
        flush = 1'b0; start = 1'b0;
        chk("idle_flush_hi", hi, m_hi);

        // Operands change and MTHI pulses while busy
        issue(3'd2, 32'hFFFF_FF9C, 32'd7);
        repeat (5) begin
            srca = $urandom; srcb = $urandom; op = 3'd4; start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            @(negedge clk);
        end
        wait_done();

        repeat (40) begin
            o = 3'($urandom_range(0, 7));
            a = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
            case ($urandom_range(0, 7))
                0:       b = 32'd0;
                1:       b = 32'hFFFF_FFFF;
                2, 3:    b = $urandom_range(1, 1000);
                default: b = $urandom;
            endcase
            issue(o, a, b);
            if (o < 3'd4) wait_done();
        end

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
